// File: rtl/mdll_fcal_pkg.sv
// Shared state encoding and default sizing for the MDLL frequency-calibration SAR.
package mdll_fcal_pkg;

  localparam int unsigned DEF_DCO_WIDTH      = 5;
  localparam int unsigned DEF_CNT_WIDTH      = 10;
  localparam int unsigned DEF_SETTLE_CYCLES  = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    MEAS,
    RELEASE,
    DECIDE,
    ERR
  } fcal_state_t;

endpackage

// File: rtl/fcal_wait_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module fcal_wait_timer
  import mdll_fcal_pkg::*;
#(
  parameter int unsigned WIDTH = $clog2(DEF_TIMEOUT_CYCLES) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/mdll_fcal_sar.sv
// Successive-approximation search of the MDLL DCO offset code against a target
// fcal count, driving the 4-phase fcal_start/fcal_ready measurement handshake.
module mdll_fcal_sar
  import mdll_fcal_pkg::*;
#(
  parameter int unsigned DCO_WIDTH      = DEF_DCO_WIDTH,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] target_cnt,
  input  logic                 fcal_ready,
  input  logic [CNT_WIDTH-1:0] fcal_cnt,
  output logic                 fcal_start,
  output logic                 load_offset,
  output logic [DCO_WIDTH-1:0] dco_ctl_offset,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] final_cnt
);

  localparam int unsigned WAIT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW       = $clog2(WAIT_MAX) + 1;
  localparam int unsigned KW       = (DCO_WIDTH > 1) ? $clog2(DCO_WIDTH) : 1;
  localparam logic [TW-1:0] SETTLE_VAL  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [KW-1:0] K_TOP       = KW'(DCO_WIDTH - 1);

  fcal_state_t          state, state_n;
  logic [KW-1:0]        k, k_n;
  logic [CNT_WIDTH-1:0] tgt, tgt_n, cmp, cmp_n, final_n;
  logic [DCO_WIDTH-1:0] dco_n;
  logic                 load_n, done_n, fcal_start_n, busy_n, err_n;
  logic                 ready_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 tmr_load, tmr_expired;
  logic [TW-1:0]        tmr_val;

  fcal_wait_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // All outputs are next-state values registered here, so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      k              <= K_TOP;
      tgt            <= '0;
      cmp            <= '0;
      ready_q        <= 1'b0;
      cnt_q          <= '0;
      fcal_start     <= 1'b0;
      load_offset    <= 1'b0;
      dco_ctl_offset <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout_err    <= 1'b0;
      final_cnt      <= '0;
    end else begin
      state          <= state_n;
      k              <= k_n;
      tgt            <= tgt_n;
      cmp            <= cmp_n;
      ready_q        <= fcal_ready;
      cnt_q          <= fcal_cnt;
      fcal_start     <= fcal_start_n;
      load_offset    <= load_n;
      dco_ctl_offset <= dco_n;
      busy           <= busy_n;
      done           <= done_n;
      timeout_err    <= err_n;
      final_cnt      <= final_n;
    end
  end

  always_comb begin
    state_n      = state;
    k_n          = k;
    tgt_n        = tgt;
    cmp_n        = cmp;
    final_n      = final_cnt;
    dco_n        = dco_ctl_offset;
    fcal_start_n = fcal_start;
    busy_n       = busy;
    err_n        = timeout_err;
    load_n       = 1'b0;
    done_n       = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    unique case (state)
      IDLE, ERR: begin
        if (start) begin
          state_n               = LOAD;
          tgt_n                 = target_cnt;
          err_n                 = 1'b0;
          k_n                   = K_TOP;
          dco_n                 = '0;
          dco_n[DCO_WIDTH-1]    = 1'b1;
          load_n                = 1'b1;
          busy_n                = 1'b1;
        end
      end
      LOAD: begin
        state_n  = SETTLE;
        tmr_load = 1'b1;
        tmr_val  = SETTLE_VAL;
      end
      SETTLE: begin
        if (tmr_expired) begin
          state_n      = MEAS;
          fcal_start_n = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = TIMEOUT_VAL;
        end
      end
      MEAS: begin
        if (ready_q) begin
          state_n      = RELEASE;
          final_n      = cnt_q;
          cmp_n        = cnt_q;
          fcal_start_n = 1'b0;
          tmr_load     = 1'b1;
          tmr_val      = TIMEOUT_VAL;
        end else if (tmr_expired) begin
          state_n      = ERR;
          err_n        = 1'b1;
          fcal_start_n = 1'b0;
          busy_n       = 1'b0;
        end
      end
      RELEASE: begin
        if (!ready_q) begin
          state_n = DECIDE;
        end else if (tmr_expired) begin
          state_n      = ERR;
          err_n        = 1'b1;
          fcal_start_n = 1'b0;
          busy_n       = 1'b0;
        end
      end
      DECIDE: begin
        if (cmp > tgt) dco_n[k] = 1'b0;
        load_n = 1'b1;
        if (k != '0) begin
          dco_n[k - KW'(1)] = 1'b1;
          k_n               = k - KW'(1);
          state_n           = LOAD;
        end else begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdll_fcal_sar.sv
// Directed bench for mdll_fcal_sar with a behavioural MDLL returning count = 8*code.
module tb_mdll_fcal_sar;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] target_cnt = '0;
  logic       fcal_ready = 1'b0;
  logic [9:0] fcal_cnt = '0;
  logic       fcal_start, load_offset, busy, done, timeout_err;
  logic [3:0] dco_ctl_offset;
  logic [9:0] final_cnt;

  int checks = 0;
  int errors = 0;

  mdll_fcal_sar #(
    .DCO_WIDTH      (4),
    .CNT_WIDTH      (10),
    .SETTLE_CYCLES  (3),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .target_cnt     (target_cnt),
    .fcal_ready     (fcal_ready),
    .fcal_cnt       (fcal_cnt),
    .fcal_start     (fcal_start),
    .load_offset    (load_offset),
    .dco_ctl_offset (dco_ctl_offset),
    .busy           (busy),
    .done           (done),
    .timeout_err    (timeout_err),
    .final_cnt      (final_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  logic       clr_mon = 1'b0;
  int         n_load, n_meas, n_done;
  int unsigned meas_cyc, err_cyc;
  logic [3:0] loads [0:7];
  logic       fs_prev = 1'b0, err_prev = 1'b0;

  always @(negedge clk) begin
    if (clr_mon) begin
      n_load <= 0;
      n_meas <= 0;
      n_done <= 0;
    end else begin
      if (load_offset) begin
        if (n_load < 8) loads[n_load] <= dco_ctl_offset;
        n_load <= n_load + 1;
      end
      if (fcal_start && !fs_prev) begin
        n_meas   <= n_meas + 1;
        meas_cyc <= cyc;
      end
      if (timeout_err && !err_prev) err_cyc <= cyc;
      if (done) n_done <= n_done + 1;
    end
    fs_prev  <= fcal_start;
    err_prev <= timeout_err;
  end

  // MDLL model: ready 5 cycles after fcal_start, drops 3 cycles after fcal_start falls
  int hang_trial = 0;
  logic stuck = 1'b0;
  int rise_cnt = 0, fall_cnt = 0;

  always @(negedge clk) begin
    if (fcal_start) begin
      fall_cnt <= 0;
      if (!fcal_ready) begin
        if (rise_cnt == 4) begin
          if (n_meas != hang_trial) begin
            fcal_ready <= 1'b1;
            fcal_cnt   <= {3'b000, dco_ctl_offset, 3'b000};
          end
        end else begin
          rise_cnt <= rise_cnt + 1;
        end
      end
    end else begin
      rise_cnt <= 0;
      if (fcal_ready && !stuck) begin
        if (fall_cnt == 2) begin
          fcal_ready <= 1'b0;
          fall_cnt   <= 0;
        end else begin
          fall_cnt <= fall_cnt + 1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    @(posedge clk); #1; clr_mon = 1'b1;
    @(posedge clk); #1; clr_mon = 1'b0;
  endtask

  task automatic do_start(input logic [9:0] t);
    @(posedge clk); #1; start = 1'b1; target_cnt = t;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done || timeout_err) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s no done/timeout_err within bound", nm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({fcal_start, load_offset, dco_ctl_offset, busy, done, timeout_err, final_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got fs=%b lo=%b dco=%0d busy=%b done=%b err=%b fc=%0d required all 0",
               fcal_start, load_offset, dco_ctl_offset, busy, done, timeout_err, final_cnt);
    end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_nominal();
    int exp_l [5] = '{8, 4, 6, 7, 6};
    clear_mon();
    do_start(10'd50);
    wait_end("nominal");
    checks++;
    if (done !== 1'b1 || load_offset !== 1'b1) begin
      errors++; $display("FAIL nom_done_load got done=%b load=%b required 1 1", done, load_offset);
    end
    checks++;
    if (dco_ctl_offset !== 4'd6) begin errors++; $display("FAIL nom_dco got %0d required 6", dco_ctl_offset); end
    checks++;
    if (final_cnt !== 10'd56) begin errors++; $display("FAIL nom_final_cnt got %0d required 56", final_cnt); end
    repeat (4) @(negedge clk);
    checks++;
    if (n_meas !== 4) begin errors++; $display("FAIL nom_meas got %0d required 4", n_meas); end
    checks++;
    if (n_load !== 5) begin errors++; $display("FAIL nom_loads got %0d required 5", n_load); end
    checks++;
    if (n_done !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL nom_done_count got %0d busy=%b required 1 busy=0", n_done, busy);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (loads[i] !== 4'(exp_l[i])) begin
        errors++; $display("FAIL nom_trial%0d got %0d required %0d", i, loads[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_extremes();
    int tgt [3]  = '{48, 1023, 0};
    int edco [3] = '{6, 15, 0};
    int efc [3]  = '{56, 120, 8};
    for (int i = 0; i < 3; i++) begin
      clear_mon();
      do_start(10'(tgt[i]));
      wait_end("extreme");
      checks++;
      if (dco_ctl_offset !== 4'(edco[i]) || final_cnt !== 10'(efc[i]) || done !== 1'b1) begin
        errors++;
        $display("FAIL extreme_t%0d got dco=%0d fc=%0d done=%b required dco=%0d fc=%0d done=1",
                 tgt[i], dco_ctl_offset, final_cnt, done, edco[i], efc[i]);
      end
    end
  endtask

  task automatic test_timeout();
    hang_trial = 2;
    clear_mon();
    do_start(10'd50);
    wait_end("timeout");
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || fcal_start !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL to_flags got err=%b busy=%b fs=%b done=%b required 1 0 0 0",
               timeout_err, busy, fcal_start, done);
    end
    checks++;
    if (dco_ctl_offset !== 4'd4) begin errors++; $display("FAIL to_dco got %0d required 4", dco_ctl_offset); end
    repeat (3) @(negedge clk);
    checks++;
    if (err_cyc - meas_cyc !== 64) begin
      errors++; $display("FAIL to_latency got %0d required 64", err_cyc - meas_cyc);
    end
    checks++;
    if (n_done !== 0 || n_meas !== 2 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_counts got done=%0d meas=%0d err=%b required 0 2 1", n_done, n_meas, timeout_err);
    end
    hang_trial = 0;
    clear_mon();
    do_start(10'd50);
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL to_restart_clear got err=%b busy=%b required 0 1", timeout_err, busy);
    end
    wait_end("timeout_restart");
    checks++;
    if (done !== 1'b1 || dco_ctl_offset !== 4'd6 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL to_restart_result got done=%b dco=%0d err=%b required 1 6 0",
                         done, dco_ctl_offset, timeout_err);
    end
  endtask

  task automatic test_stuck_ready();
    stuck = 1'b1;
    clear_mon();
    do_start(10'd50);
    wait_end("stuck");
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || dco_ctl_offset !== 4'd8) begin
      errors++; $display("FAIL stuck_result got err=%b busy=%b dco=%0d required 1 0 8",
                         timeout_err, busy, dco_ctl_offset);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (n_meas !== 1 || n_done !== 0) begin
      errors++; $display("FAIL stuck_counts got meas=%0d done=%0d required 1 0", n_meas, n_done);
    end
    stuck = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int loads_at_rst;
    bit seen = 1'b0;
    clear_mon();
    do_start(10'd50);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (n_load == 3) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_third_load got %0d loads required 3", n_load); end
    @(posedge clk); #1; rst = 1'b1; start = 1'b1; target_cnt = 10'd50;
    @(posedge clk); #1; rst = 1'b0; start = 1'b0;
    @(negedge clk);
    loads_at_rst = n_load;
    checks++;
    if ({fcal_start, load_offset, dco_ctl_offset, busy, done, timeout_err, final_cnt} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got fs=%b lo=%b dco=%0d busy=%b done=%b err=%b fc=%0d required all 0",
               fcal_start, load_offset, dco_ctl_offset, busy, done, timeout_err, final_cnt);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (n_load !== loads_at_rst || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_quiet got loads=%0d busy=%b required %0d 0", n_load, busy, loads_at_rst);
    end
    clear_mon();
    do_start(10'd50);
    wait_end("rstmid_restart");
    checks++;
    if (loads[0] !== 4'd8 || dco_ctl_offset !== 4'd6) begin
      errors++; $display("FAIL rstmid_restart got first=%0d dco=%0d required 8 6", loads[0], dco_ctl_offset);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    do_start(10'd50);
    for (int i = 0; i < 4; i++) begin
      repeat (6) @(posedge clk);
      #1; start = 1'b1; target_cnt = 10'd10;
      @(posedge clk); #1; start = 1'b0;
    end
    wait_end("busy_start");
    checks++;
    if (dco_ctl_offset !== 4'd6 || final_cnt !== 10'd56 || done !== 1'b1) begin
      errors++; $display("FAIL busy_start_result got dco=%0d fc=%0d done=%b required 6 56 1",
                         dco_ctl_offset, final_cnt, done);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (n_done !== 1 || n_meas !== 4 || busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_counts got done=%0d meas=%0d busy=%b required 1 4 0",
                         n_done, n_meas, busy);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_extremes();
    test_timeout();
    test_stuck_ready();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdll_fcal_sar.md
Name: mdll_fcal_sar

Overview:
- Hardware sequencer for MDLL frequency calibration.
- Runs a successive-approximation (binary) search on the MDLL DCO offset code. For each trial code it drives the MDLL's fcal measurement handshake and compares the returned count to a target.
- Sits between the JTAG-controlled debug registers and the MDLL debug controls, replacing manual software search over JTAG.

Parameters:
- DCO_WIDTH, 5: width of the DCO offset code; one search step per bit.
- CNT_WIDTH, 10: width of the fcal count and the target.
- SETTLE_CYCLES, 16: clk cycles to wait after a load_offset pulse before starting a measurement; minimum 1.
- TIMEOUT_CYCLES, 4096: maximum clk cycles to wait for fcal_ready to rise, or to fall.

Ports:
- clk  in  1  block clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin calibration; ignored while busy=1.
- target_cnt  in  CNT_WIDTH  desired fcal count; sampled on an accepted start.
- fcal_ready  in  1  MDLL measurement-complete flag.
- fcal_cnt  in  CNT_WIDTH  MDLL count; valid while fcal_ready=1.
- fcal_start  out  1  measurement request to the MDLL.
- load_offset  out  1  one-cycle strobe that loads dco_ctl_offset into the MDLL.
- dco_ctl_offset  out  DCO_WIDTH  trial code during search; final code after done.
- busy  out  1  high from the cycle after an accepted start until done or err.
- done  out  1  one-cycle pulse on successful completion.
- timeout_err  out  1  sticky error flag; cleared by the next accepted start or by rst.
- final_cnt  out  CNT_WIDTH  count from the last completed measurement.

Behaviour:
- Reset: on rst=1 at a clock edge:
  - all outputs go to 0;
  - state goes to IDLE;
  - the bit index goes to DCO_WIDTH-1.
  - rst mid-search aborts immediately. No load_offset is issued during reset.
- States: IDLE, LOAD, SETTLE, MEAS, RELEASE, DECIDE, ERR.
- IDLE:
  - start=1 latches target_cnt, clears timeout_err, sets bit index k=DCO_WIDTH-1, sets dco_ctl_offset = 1<<k, then goes to LOAD.
- LOAD:
  - load_offset=1 for exactly this one cycle, then go to SETTLE.
- SETTLE:
  - count SETTLE_CYCLES cycles, then go to MEAS.
- MEAS:
  - fcal_start=1.
  - Registered fcal_ready=1: capture fcal_cnt into final_cnt and into a compare register, drop fcal_start, go to RELEASE.
- RELEASE:
  - fcal_start=0; wait for fcal_ready=0 (4-phase handshake), then go to DECIDE.
- DECIDE (one cycle):
  - Higher code means higher frequency.
  - Unsigned compare: if captured count > target, clear bit k; equal or less keeps it.
  - If k>0: set bit k-1, decrement k, go to LOAD.
  - If k=0: apply the final bit decision, issue one more load_offset pulse in the same cycle as done=1, drop busy, go to IDLE.
- Measurement count:
  - exactly DCO_WIDTH measurements;
  - DCO_WIDTH+1 load_offset pulses (one per trial plus the final load).
- Timeout:
  - one counter, reset on entry to MEAS and on entry to RELEASE.
  - Reaching TIMEOUT_CYCLES in either state: timeout_err=1, fcal_start=0, busy=0, go to ERR.
  - dco_ctl_offset holds the last trial code.
  - ERR behaves as IDLE: start is accepted from ERR.
- Latency bound (no timeout), per bit: 1 (LOAD) + SETTLE_CYCLES + ready-rise wait + 1 + ready-fall wait + 1 (DECIDE).
- Boundary conditions:
  - fcal_ready already high on MEAS entry: capture on the first MEAS cycle.
  - start during busy: ignored.
  - start in the same cycle as rst: rst wins.
  - target_cnt changes mid-search: no effect, because it is latched.
  - target=0: all bits clear unless a count of 0 is measured.
  - target at maximum (all ones): all bits kept.
- Outputs are registered. No combinational path from any input to any output.

Decomposition:
- Package mdll_fcal_pkg:
  - state enum fcal_state_t;
  - default localparams for widths and timing.
- One sub-module, fcal_wait_timer: loadable down-counter shared by the SETTLE and timeout functions. Ports: clk, rst, load, load_val, expired.
- The SAR register and the compare stay in the top module.

Test Plan:
- Nominal search. DCO_WIDTH=4; bench MDLL model returns count = 8*code, ready 5 cycles after fcal_start, ready low 3 cycles after fcal_start falls; target=50.
  -> trials 8,4,6,7; final dco_ctl_offset=6; final_cnt=56; 4 measurements; 5 load_offset pulses; one done pulse.
- Equality and extremes, same model.
  -> target=48 gives 6; target=1023 gives 15; target=0 gives 0.
- Timeout: model never raises ready on the 2nd trial; TIMEOUT_CYCLES=64.
  -> timeout_err=1 exactly 64 cycles after MEAS entry; busy=0; no done; fcal_start=0.
  -> A new start clears timeout_err and completes normally.
- Stuck-high ready: ready never falls after the 1st measurement.
  -> timeout in RELEASE; dco_ctl_offset stays 8.
- Reset mid-search: rst=1 during SETTLE of the 3rd trial.
  -> next cycle all outputs 0; no load_offset; a new start restarts at code 8.
- Start while busy, plus target change mid-run: extra start pulses and target changed to 10 during the run.
  -> ignored; result still 6 for the original target=50.
